// File: rtl/nn_pkg.sv
// Shared types and sizing for the MLP output path.
// Covers the output beat width, class index, reader FSM state and result record.
package nn_pkg;

    localparam int NN_OUTPUTS        = 2;
    localparam int OUTPUT_DATA_WIDTH = 32;

    typedef logic [7:0]                          nn_class_t;
    typedef logic signed [OUTPUT_DATA_WIDTH-1:0] nn_score_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } nn_reader_state_e;

    typedef struct packed {
        nn_class_t cls;
        nn_score_t max;
        logic      err;
    } nn_result_t;

endpackage

// File: rtl/nn_result_reader_if.sv
// Beat input and result output ports of the NN result reader.
// Both ports use valid/ready: a transfer happens on a rising clk edge with valid && ready.
interface nn_result_reader_if
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = NN_OUTPUTS,
    parameter int DATA_WIDTH  = OUTPUT_DATA_WIDTH,
    parameter int CLASS_W     = 8,
    parameter int CNT_W       = 16
);
    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_WIDTH-1:0]           in_data;
    logic                            in_last;
    logic                            out_valid;
    logic                            out_ready;
    logic [CLASS_W-1:0]              out_class;
    logic [DATA_WIDTH-1:0]           out_max;
    logic [NUM_CLASSES*DATA_WIDTH-1:0] out_scores;
    logic                            out_err;
    logic [CNT_W-1:0]                out_count;
    nn_reader_state_e                dbg_state;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_max, out_scores, out_err, out_count, dbg_state
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_class, out_max, out_scores, out_err, out_count, dbg_state
    );

endinterface

// File: rtl/nn_result_reader.sv
// Collects one inference worth of signed scores, tracks the running argmax and
// holds a single classification result until downstream takes it.
module nn_result_reader
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = NN_OUTPUTS,
    parameter int DATA_WIDTH  = OUTPUT_DATA_WIDTH,
    parameter int CLASS_W     = 8,
    parameter int CNT_W       = 16
) (
    input logic              clk,
    input logic              rst,
    nn_result_reader_if.slave bus
);

    nn_reader_state_e                  state_q;
    logic [CLASS_W-1:0]                idx_q;
    logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_q;
    logic signed [DATA_WIDTH-1:0]      max_q;
    logic [CLASS_W-1:0]                class_q;
    logic                              err_q;
    logic                              out_valid_q;
    logic [CNT_W-1:0]                  count_q;

    logic accept;
    logic at_last_idx;
    logic end_beat;

    assign accept      = bus.in_valid && (state_q != EMIT);
    assign at_last_idx = (idx_q == CLASS_W'(NUM_CLASSES - 1));
    assign end_beat    = bus.in_last || at_last_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            scores_q    <= '0;
            max_q       <= '0;
            class_q     <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE, COLLECT: begin
                    if (accept) begin
                        // First beat clears every slot so short frames report zeros.
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            if (CLASS_W'(k) == idx_q)
                                scores_q[k*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
                            else if (idx_q == '0)
                                scores_q[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        end
                        // Strict greater-than keeps the lower index on ties.
                        if ((idx_q == '0) || ($signed(bus.in_data) > max_q)) begin
                            max_q   <= $signed(bus.in_data);
                            class_q <= idx_q;
                        end
                        if (end_beat) begin
                            state_q     <= EMIT;
                            out_valid_q <= 1'b1;
                            idx_q       <= '0;
                            err_q       <= (bus.in_last != at_last_idx);
                        end else begin
                            state_q <= COLLECT;
                            idx_q   <= idx_q + CLASS_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        count_q     <= count_q + CNT_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_q != EMIT);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_class  = class_q;
    assign bus.out_max    = max_q;
    assign bus.out_scores = scores_q;
    assign bus.out_err    = err_q;
    assign bus.out_count  = count_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: doc/nn_result_reader.md
Name: nn_result_reader

Overview:
- Consumer end of the MLP output stream. It accepts the NN_OUTPUTS signed Q16.16 output beats of one inference over a valid/ready handshake.
- It buffers all scores, tracks a running signed argmax, and presents one classification result per inference on a second valid/ready port.
- It sits between the MLP core output and the sleep-stage reporting logic.

Parameters:
- NUM_CLASSES, nn_pkg::NN_OUTPUTS (2): beats per inference; legal range 1..255.
- DATA_WIDTH, nn_pkg::OUTPUT_DATA_WIDTH (32): width of each signed Q16.16 score.
- CLASS_W, 8: width of the class index.
- CNT_W, 16: width of the inference counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  NN output beat valid.
- in_ready  out  1  reader can accept a beat.
- in_data  in  DATA_WIDTH  signed Q16.16 score.
- in_last  in  1  final beat of the current inference.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_class  out  CLASS_W  index of the maximum score.
- out_max  out  DATA_WIDTH  maximum score value.
- out_scores  out  NUM_CLASSES*DATA_WIDTH  all scores; class k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_err  out  1  beat count did not match NUM_CLASSES.
- out_count  out  CNT_W  number of results delivered so far; wraps.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_class=0, out_max=0, out_scores=0, out_err=0, out_count=0, beat index=0.
- FSM states:
  - IDLE: no beats received yet.
  - COLLECT: at least one beat of the current inference received.
  - EMIT: result held on the output port.
- in_ready = (state != EMIT). It is registered-state driven, with no combinational path from out_ready.
- A beat is accepted when in_valid && in_ready. On acceptance:
  - in_data is written to scores[idx].
  - If idx==0, max is loaded unconditionally and class=0.
  - Otherwise, if signed in_data > max, max and class are updated to idx.
  - Ties keep the lower index.
- End of inference occurs when an accepted beat has in_last=1 or idx==NUM_CLASSES-1. On that beat:
  - The next state is EMIT; out_valid rises in the following cycle.
  - Latency from the last beat to out_valid is 1 cycle.
  - idx resets to 0.
  - out_err is set if in_last==1 with idx!=NUM_CLASSES-1, or if idx==NUM_CLASSES-1 with in_last==0.
- On any other accepted beat: idx increments and state=COLLECT.
- Short frames: on early in_last, unwritten score slots are zeroed at the start of each inference (on idx==0 acceptance) and are reported as 0.
- Long frames: extra beats after a forced end start a new inference. In that case in_last does not arrive on the expected beat, so the error flag is raised on the first result.
- EMIT behaviour:
  - out_class, out_max, out_scores and out_err are stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid=0, out_count increments (wrapping), state=IDLE.
  - in_ready rises the cycle after the handshake, giving one bubble cycle per inference.
- Comparison is full DATA_WIDTH signed. There is no saturation and no ReLU; scores are raw logits.
- NUM_CLASSES==1: every beat ends an inference. Class=0 and max=data.
- Reset asserted mid-COLLECT or mid-EMIT: the partial or pending result is discarded and all outputs return to reset values immediately.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.

Decomposition:
- nn_pkg additions:
  - typedef logic [7:0] nn_class_t.
  - typedef logic signed [OUTPUT_DATA_WIDTH-1:0] nn_score_t.
  - typedef enum for the reader FSM states: IDLE, COLLECT, EMIT.
  - A packed struct nn_result_t {class, max, err}.
- Single module; no sub-module is natural. The argmax is one comparator inside the collect path.

Test Plan:
- Two beats 0x00010000 (1.0), then 0xFFFF0000 (-1.0) with last -> one cycle later: out_valid=1, out_class=0, out_max=0x00010000, out_err=0, out_count=1 after handshake.
- Two beats 0xFFFE0000 (-2.0), then 0xFFFF8000 (-0.5) with last -> class=1, max=0xFFFF8000; verifies the signed compare.
- Equal scores 0x00020000 on both beats -> class=0 (tie keeps the lower index).
- Hold out_ready=0 for 5 cycles after out_valid while in_valid=1 -> in_ready=0 throughout, outputs stable. Release out_ready -> in_ready=1 next cycle, and the next inference is correct.
- in_last on the first beat (0x00030000) -> out_err=1, class=0, out_scores slot 1 = 0. Separately, 2 beats with no in_last -> out_err=1, result still emitted.
- Assert rst mid-COLLECT after one beat -> out_valid=0, out_count=0. A following clean inference yields the correct class with out_err=0.
